// File: rtl/hazard_stall_ctrl_if.sv
// Decode/execute interlock bus between the SimpleRisc pipeline (master) and hazard_stall_ctrl (slave).
// HZ_PERF_CNT_EN adds the stall/flush performance counter outputs.
interface hazard_stall_ctrl_if
`ifdef HZ_PERF_CNT_EN
  #(parameter int unsigned CNT_W = 32)
`endif
  ;
  logic       valid_D;
  logic [3:0] rs1_D;
  logic [3:0] rs2_D;
  logic       use_rs1_D;
  logic       use_rs2_D;
  logic       mc_op_D;
  logic       valid_E;
  logic [3:0] rd_E;
  logic       isLd_E;
  logic       isWb_E;
  logic       isbranchtaken_E;
  logic       mc_done;
  logic       stall_F;
  logic       stall_D;
  logic       bubble_E;
  logic       flush_FD;
  logic       mc_go;
  logic       mc_abort;
  logic       mc_timeout;
  logic [1:0] hz_state;
`ifdef HZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
`endif

  modport slave (
    input  valid_D, rs1_D, rs2_D, use_rs1_D, use_rs2_D, mc_op_D,
    input  valid_E, rd_E, isLd_E, isWb_E, isbranchtaken_E, mc_done,
    output stall_F, stall_D, bubble_E, flush_FD, mc_go, mc_abort, mc_timeout, hz_state
`ifdef HZ_PERF_CNT_EN
    , output stall_cnt, flush_cnt
`endif
  );

  modport master (
    output valid_D, rs1_D, rs2_D, use_rs1_D, use_rs2_D, mc_op_D,
    output valid_E, rd_E, isLd_E, isWb_E, isbranchtaken_E, mc_done,
    input  stall_F, stall_D, bubble_E, flush_FD, mc_go, mc_abort, mc_timeout, hz_state
`ifdef HZ_PERF_CNT_EN
    , input stall_cnt, flush_cnt
`endif
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Load-use / multicycle / branch-flush interlock for the 5-stage SimpleRisc pipeline.
// Optional HZ_PERF_CNT_EN adds saturating stall and flush cycle counters.
module hazard_stall_ctrl #(
  parameter int unsigned MC_TIMEOUT = 32
`ifdef HZ_PERF_CNT_EN
  , parameter int unsigned CNT_W = 32
`endif
) (
  input  logic               clk,
  input  logic               rst,
  hazard_stall_ctrl_if.slave bus
);
  localparam int unsigned WAIT_W = 8;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MCWAIT  = 2'd1,
    ST_FLUSHED = 2'd2
  } hz_state_e;

  hz_state_e         state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              tmo_q, tmo_d;

  logic ldhz_c;
  logic stall_f_c, stall_d_c, bubble_e_c, flush_fd_c, mc_go_c, mc_abort_c;

  assign ldhz_c = bus.valid_D & bus.valid_E & bus.isLd_E & bus.isWb_E &
                  ((bus.use_rs1_D & (bus.rs1_D == bus.rd_E)) |
                   (bus.use_rs2_D & (bus.rs2_D == bus.rd_E)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next state and stall controls; branch-taken beats everything except FLUSHED.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    tmo_d      = tmo_q;
    stall_f_c  = 1'b0;
    stall_d_c  = 1'b0;
    bubble_e_c = 1'b0;
    flush_fd_c = 1'b0;
    mc_go_c    = 1'b0;
    mc_abort_c = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (bus.isbranchtaken_E) begin
          flush_fd_c = 1'b1;
          bubble_e_c = 1'b1;
          state_d    = ST_FLUSHED;
          wait_d     = '0;
        end else if (ldhz_c) begin
          stall_f_c  = 1'b1;
          stall_d_c  = 1'b1;
          bubble_e_c = 1'b1;
        end else if (bus.valid_D & bus.mc_op_D) begin
          mc_go_c    = 1'b1;
          stall_f_c  = 1'b1;
          stall_d_c  = 1'b1;
          bubble_e_c = 1'b1;
          state_d    = ST_MCWAIT;
          wait_d     = '0;
        end
      end
      ST_MCWAIT: begin
        if (bus.isbranchtaken_E) begin
          flush_fd_c = 1'b1;
          bubble_e_c = 1'b1;
          mc_abort_c = ~bus.mc_done;
          state_d    = ST_FLUSHED;
          wait_d     = '0;
        end else if (bus.mc_done) begin
          state_d = ST_RUN;
          wait_d  = '0;
        end else if (wait_q == WAIT_W'(MC_TIMEOUT - 1)) begin
          mc_abort_c = 1'b1;
          tmo_d      = 1'b1;
          state_d    = ST_RUN;
          wait_d     = '0;
        end else begin
          stall_f_c  = 1'b1;
          stall_d_c  = 1'b1;
          bubble_e_c = 1'b1;
          wait_d     = wait_q + WAIT_W'(1);
        end
      end
      ST_FLUSHED: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
        wait_d  = '0;
      end
    endcase
    // Everything is quiet while reset is held, even with hazard inputs active.
    if (!rst) begin
      stall_f_c  = 1'b0;
      stall_d_c  = 1'b0;
      bubble_e_c = 1'b0;
      flush_fd_c = 1'b0;
      mc_go_c    = 1'b0;
      mc_abort_c = 1'b0;
    end
  end

  assign bus.stall_F    = stall_f_c;
  assign bus.stall_D    = stall_d_c;
  assign bus.bubble_E   = bubble_e_c;
  assign bus.flush_FD   = flush_fd_c;
  assign bus.mc_go      = mc_go_c;
  assign bus.mc_abort   = mc_abort_c;
  assign bus.mc_timeout = tmo_q;
  assign bus.hz_state   = 2'(state_q);

`ifdef HZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating cycle counters for stall_D and flush_FD.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_d_c && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_fd_c && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`endif
endmodule
